// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM port among NUM_REQ requesters.
// Grants are combinational, the RAM command is registered, read data is routed
// back through a tag pipeline, and reads that would see stale data from a write
// still completing inside the RAM are held off by a small write scoreboard.
module dpram_port_arbiter #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int READ_LANTENCY  = 3,
    parameter int WRITE_LANTENCY = 3,
    parameter int NUM_REQ        = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ-1:0]            i_req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_din,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
    output logic                          o_ram_en,
    output logic                          o_ram_we,
    output logic [ADDR_WIDTH-1:0]         o_ram_addr,
    output logic [DATA_WIDTH-1:0]         o_ram_din,
    input  logic [DATA_WIDTH-1:0]         i_ram_dout
);

    localparam int  ID_W     = $clog2(NUM_REQ);
    // Entry 0 mirrors the write in the command stage; entry j is a write issued j cycles ago.
    // A write only blocks reads for WRITE_LANTENCY-1 transfer cycles after its own transfer.
    localparam int  HZ_DEPTH = (WRITE_LANTENCY > 1) ? WRITE_LANTENCY - 1 : 1;
    localparam bit  HZ_EN    = (WRITE_LANTENCY > 1);

    logic [ID_W-1:0]       rr_ptr;
    logic [NUM_REQ-1:0]    hz_hit;
    logic [NUM_REQ-1:0]    eligible;
    logic                  gnt_any;
    logic [ID_W-1:0]       gnt_idx;
    logic [ID_W-1:0]       ptr_next;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_din;

    logic [HZ_DEPTH-1:0]   hz_valid;
    logic [ADDR_WIDTH-1:0] hz_addr [0:HZ_DEPTH-1];

    logic [READ_LANTENCY:0] tag_valid;
    logic [ID_W-1:0]        tag_id [0:READ_LANTENCY];

    // Flag requesters whose read address matches a write still settling in the RAM.
    always_comb begin
        hz_hit = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < HZ_DEPTH; j++) begin
                if (HZ_EN && hz_valid[j] &&
                    hz_addr[j] == i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    hz_hit[k] = 1'b1;
                end
            end
        end
    end

    assign eligible = i_req_valid & (i_req_we | ~hz_hit);

    // Pick the first eligible requester at or after the pointer, wrapping around.
    always_comb begin : p_grant
        int idx;
        idx         = 0;
        o_req_ready = '0;
        gnt_any     = 1'b0;
        gnt_idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_any && !i_rst && eligible[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
        if (gnt_any) o_req_ready[gnt_idx] = 1'b1;
    end

    assign ptr_next = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    assign sel_we   = i_req_we[gnt_idx];
    assign sel_addr = i_req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_din  = i_req_din[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

    // Register the granted request onto the RAM port and advance the pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ram_en   <= 1'b0;
            o_ram_we   <= 1'b0;
            o_ram_addr <= '0;
            o_ram_din  <= '0;
            rr_ptr     <= '0;
        end else begin
            o_ram_en <= gnt_any;
            o_ram_we <= gnt_any & sel_we;
            if (gnt_any) begin
                o_ram_addr <= sel_addr;
                o_ram_din  <= sel_din;
                rr_ptr     <= ptr_next;
            end
        end
    end

    // Track recently issued writes so conflicting reads can be held back.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hz_valid <= '0;
            for (int j = 0; j < HZ_DEPTH; j++) hz_addr[j] <= '0;
        end else begin
            hz_valid[0] <= gnt_any & sel_we;
            hz_addr[0]  <= sel_addr;
            for (int j = 1; j < HZ_DEPTH; j++) begin
                hz_valid[j] <= hz_valid[j-1];
                hz_addr[j]  <= hz_addr[j-1];
            end
        end
    end

    // Carry the requester id of each read alongside it through the RAM latency.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tag_valid <= '0;
            for (int s = 0; s <= READ_LANTENCY; s++) tag_id[s] <= '0;
        end else begin
            tag_valid[0] <= gnt_any & ~sel_we;
            tag_id[0]    <= gnt_idx;
            for (int s = 1; s <= READ_LANTENCY; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
        end
    end

    // Capture RAM read data and strobe the owning requester.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
        end else begin
            o_rsp_data  <= i_ram_dout;
            o_rsp_valid <= '0;
            if (tag_valid[READ_LANTENCY]) o_rsp_valid[tag_id[READ_LANTENCY]] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Scoreboard bench for dpram_port_arbiter: a reference model predicts grants,
// RAM commands and read responses; a monitor compares what the DUT presents.
module tb_dpram_port_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int RL = 3;
    localparam int WL = 3;
    localparam int N  = 4;

    logic              i_clk;
    logic              i_rst;
    logic [N-1:0]      i_req_valid;
    logic [N-1:0]      o_req_ready;
    logic [N-1:0]      i_req_we;
    logic [N*AW-1:0]   i_req_addr;
    logic [N*DW-1:0]   i_req_din;
    logic [N-1:0]      o_rsp_valid;
    logic [DW-1:0]     o_rsp_data;
    logic              o_ram_en;
    logic              o_ram_we;
    logic [AW-1:0]     o_ram_addr;
    logic [DW-1:0]     o_ram_din;
    logic [DW-1:0]     i_ram_dout;

    dpram_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LANTENCY(RL),
        .WRITE_LANTENCY(WL), .NUM_REQ(N)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_din(i_req_din),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
        .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
        .o_ram_din(o_ram_din), .i_ram_dout(i_ram_dout)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    typedef struct {
        int            due;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    cmd_t cmdq[$];
    rsp_t rspq[$];

    int total = 0;
    int bad   = 0;

    // requester-side state (held until granted)
    bit            rv  [N];
    bit            rwe [N];
    logic [AW-1:0] ra  [N];
    logic [DW-1:0] rd  [N];

    // reference model
    int            ptr;
    int            last_wr [32];
    logic [DW-1:0] ref_mem [32];
    bit            mon_on  = 1'b0;
    int            rst_cyc = -100;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // One bench cycle: drive requests, predict the grant, and queue expected results.
    task automatic step(input bit rst);
        logic [N-1:0] exp_g;
        int g;
        int k;
        @(negedge i_clk);
        i_rst = rst;
        for (int j = 0; j < N; j++) begin
            i_req_valid[j]          = rv[j];
            i_req_we[j]             = rwe[j];
            i_req_addr[j*AW +: AW]  = ra[j];
            i_req_din[j*DW +: DW]   = rd[j];
        end
        #1;
        g = -1;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                k = (ptr + i) % N;
                if (g < 0 && rv[k] && (rwe[k] || cyc >= last_wr[ra[k]] + WL)) g = k;
            end
        end
        exp_g = '0;
        if (g >= 0) exp_g[g] = 1'b1;
        check("grant", 64'(o_req_ready), 64'(exp_g));
        if (rst) begin
            ptr = 0;
            for (int a = 0; a < 32; a++) last_wr[a] = -1000;
            cmdq.delete();
            rspq.delete();
            rst_cyc = cyc;
        end else if (g >= 0) begin
            ptr = (g + 1) % N;
            cmdq.push_back('{cyc + 1, rwe[g], ra[g], rd[g]});
            if (rwe[g]) begin
                ref_mem[ra[g]] = rd[g];
                last_wr[ra[g]] = cyc;
            end else begin
                rspq.push_back('{cyc + 2 + RL, g, ref_mem[ra[g]]});
            end
            rv[g] = 1'b0;
        end
    endtask

    task automatic set_req(input int k, input bit we, input int addr, input logic [DW-1:0] din);
        rv[k]  = 1'b1;
        rwe[k] = we;
        ra[k]  = AW'(addr);
        rd[k]  = din;
    endtask

    // RAM model: writes become visible WL cycles after issue, reads return after RL cycles.
    initial begin : ram_model
        logic [DW-1:0] mem    [32];
        logic [DW-1:0] slot   [16];
        bit            slot_v [16];
        cmd_t          pend[$];
        cmd_t          w;
        for (int a = 0; a < 32; a++) mem[a] = 32'h1000_0000 + a;
        for (int s = 0; s < 16; s++) slot_v[s] = 1'b0;
        i_ram_dout = '0;
        forever begin
            @(negedge i_clk);
            while (pend.size() > 0 && pend[0].due <= cyc) begin
                w = pend.pop_front();
                mem[w.addr] = w.data;
            end
            if (o_ram_en === 1'b1) begin
                if (o_ram_we) pend.push_back('{cyc + WL, 1'b1, o_ram_addr, o_ram_din});
                else begin
                    slot[(cyc + RL) % 16]   = mem[o_ram_addr];
                    slot_v[(cyc + RL) % 16] = 1'b1;
                end
            end
            if (slot_v[cyc % 16]) begin
                i_ram_dout          = slot[cyc % 16];
                slot_v[cyc % 16]    = 1'b0;
            end else begin
                i_ram_dout = $urandom;
            end
        end
    end

    // Monitor: compare RAM commands and responses with the scoreboard queues.
    initial begin : monitor
        cmd_t          c;
        rsp_t          r;
        logic [N-1:0]  ev;
        forever begin
            @(negedge i_clk);
            if (mon_on) begin
                if (cyc == rst_cyc + 1) begin
                    check("reset_ram_outs", 64'({o_ram_en, o_ram_we, o_ram_addr, o_ram_din}), 64'd0);
                    check("reset_rsp_outs", 64'({o_rsp_valid, o_rsp_data}), 64'd0);
                end
                if (cmdq.size() > 0 && cmdq[0].due == cyc) begin
                    c = cmdq.pop_front();
                    check("ram_cmd", 64'({o_ram_en, o_ram_we, o_ram_addr, o_ram_din}),
                          64'({1'b1, c.we, c.addr, c.data}));
                end else begin
                    check("ram_idle", 64'(o_ram_en), 64'd0);
                end
                if (rspq.size() > 0 && rspq[0].due == cyc) begin
                    r  = rspq.pop_front();
                    ev = '0;
                    ev[r.id] = 1'b1;
                    check("rsp", 64'({o_rsp_valid, o_rsp_data}), 64'({ev, r.data}));
                end else begin
                    check("rsp_idle", 64'(o_rsp_valid), 64'd0);
                end
            end
        end
    end

    initial begin : main
        i_rst       = 1'b1;
        i_req_valid = '0;
        i_req_we    = '0;
        i_req_addr  = '0;
        i_req_din   = '0;
        ptr         = 0;
        for (int a = 0; a < 32; a++) begin
            ref_mem[a] = 32'h1000_0000 + a;
            last_wr[a] = -1000;
        end
        for (int k = 0; k < N; k++) begin
            rv[k] = 1'b0; rwe[k] = 1'b0; ra[k] = '0; rd[k] = '0;
        end

        // reset with a pending read: no grant while reset is high
        set_req(0, 1'b0, 5, 32'h0);
        step(1'b1);
        mon_on = 1'b1;
        step(1'b1);
        // lone read from requester 0 granted first
        step(1'b0);
        repeat (6) step(1'b0);

        // idle: pointer must not move, then lone req3, then req0 wins over req1
        repeat (10) step(1'b0);
        set_req(3, 1'b0, 7, 32'h0);
        step(1'b0);
        set_req(0, 1'b0, 1, 32'h0);
        set_req(1, 1'b0, 2, 32'h0);
        repeat (3) step(1'b0);
        repeat (6) step(1'b0);

        // all four read continuously
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < N; k++) if (!rv[k]) set_req(k, 1'b0, k, 32'($urandom));
            step(1'b0);
        end
        for (int k = 0; k < N; k++) rv[k] = 1'b0;
        repeat (8) step(1'b0);

        // write-then-read hazard on addr 3
        set_req(1, 1'b1, 3, 32'h0000_00A5);
        step(1'b0);
        set_req(2, 1'b0, 3, 32'h0);
        set_req(3, 1'b0, 4, 32'h0);
        repeat (12) step(1'b0);

        // lone write: no response
        set_req(2, 1'b1, 9, 32'hDEAD_BEEF);
        repeat (8) step(1'b0);

        // randomized traffic over a small address range to provoke hazards
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < N; k++) begin
                if (!rv[k] && $urandom_range(3, 0) != 0)
                    set_req(k, $urandom_range(2, 0) == 0, $urandom_range(5, 0), 32'($urandom));
            end
            step(1'b0);
        end
        repeat (20) step(1'b0);
        for (int k = 0; k < N; k++) rv[k] = 1'b0;
        repeat (10) step(1'b0);

        // reset while a read is in flight: its response must be dropped
        set_req(0, 1'b0, 2, 32'h0);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        set_req(1, 1'b0, 6, 32'h0);
        set_req(2, 1'b0, 6, 32'h0);
        repeat (12) step(1'b0);

        check("queues_drained", 64'(cmdq.size() + rspq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Shares one port (A or B) of the dual-port RAM among NUM_REQ requesters using round-robin arbitration.
- Issues one RAM operation per cycle through a registered command stage.
- Tracks in-flight reads over the RAM read latency and routes returned data to the originating requester.
- Holds off reads that would hit an address still being written (write-latency hazard).
- One instance sits in front of each RAM port that has more than one master.

Parameters:
ADDR_WIDTH, 5, RAM address width
DATA_WIDTH, 32, RAM data width
READ_LANTENCY, 3, cycles from RAM read issue to data on i_ram_dout; must match the RAM instance, >=1
WRITE_LANTENCY, 3, cycles from RAM write issue until a read of the same address returns new data, >=1
NUM_REQ, 4, number of requesters, 2..8

Ports:
i_clk  input  1  single clock; all logic on rising edge
i_rst  input  1  synchronous reset, active-high
i_req_valid  input  NUM_REQ  per-requester request valid
o_req_ready  output  NUM_REQ  one-hot grant; transfer when valid&ready
i_req_we  input  NUM_REQ  1=write, 0=read, per requester
i_req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
i_req_din  input  NUM_REQ*DATA_WIDTH  packed write data, same packing
o_rsp_valid  output  NUM_REQ  one-cycle read-data strobe for requester k
o_rsp_data  output  DATA_WIDTH  read data, qualified by o_rsp_valid
o_ram_en  output  1  RAM port enable
o_ram_we  output  1  RAM port write enable
o_ram_addr  output  ADDR_WIDTH  RAM port address
o_ram_din  output  DATA_WIDTH  RAM port write data
i_ram_dout  input  DATA_WIDTH  RAM port read data

Behaviour:
- Reset: all registered outputs are 0. The round-robin pointer is 0. The tag pipeline and write scoreboard are cleared. Reads in flight at reset never produce o_rsp_valid.
- Eligibility: requester k is eligible when i_req_valid[k]=1, and either it is a write, or it is a read that passes the hazard check.
- Grant: o_req_ready is combinational. It is one-hot on the first eligible requester at or after the pointer, searching upward with wrap-around. It is all-zero if no requester is eligible, and all-zero while i_rst=1.
- Pointer update: after a transfer to requester k, the pointer becomes (k+1) mod NUM_REQ. With no transfer, the pointer is unchanged.
- Command stage: a request transferred in cycle c drives o_ram_en=1, o_ram_we, o_ram_addr and o_ram_din in cycle c+1. o_ram_en=0 in any cycle with no transfer in the previous cycle. o_ram_addr and o_ram_din hold their last values when idle. Throughput is one operation per cycle.
- RAM contract: a read issued in cycle i has valid data on i_ram_dout in cycle i+READ_LANTENCY.
- Tag pipeline: READ_LANTENCY+1 stages, each carrying {valid, requester id}, loaded only for reads.
  - o_rsp_data is registered from i_ram_dout.
  - o_rsp_valid[k] is high for exactly one cycle, c+2+READ_LANTENCY, for a read transferred in cycle c.
  - Responses are in issue order and cannot be back-pressured.
  - Writes produce no response.
- Hazard scoreboard: records {valid, addr} of each write for WRITE_LANTENCY cycles from its RAM issue cycle w.
  - A read to the same address may be transferred only if its issue cycle is at least w+WRITE_LANTENCY, i.e. transfer cycle >= w+WRITE_LANTENCY-1.
  - The check includes the write currently in the command stage.
  - A blocked read is skipped, and other eligible requesters are granted. The blocked requester keeps valid asserted.
- Back-to-back writes to the same address are allowed with no stall.
- When valid is asserted, a requester must hold we, addr and din stable until ready.

Test Plan:
1. READ_LANTENCY=3, RAM preloaded addr 5=0x1234. Req0 read addr 5, valid in cycle c0 -> o_req_ready=0001 in c0; o_ram_en=1, we=0, addr=5 in c0+1; o_rsp_valid=0001 with o_rsp_data=0x1234 only in c0+5.
2. All four requesters read continuously, addrs 0..3 -> grants 0001,0010,0100,1000,0001 in consecutive cycles; o_ram_en high every cycle; responses return in the same order, one per cycle.
3. Req1 writes 0xA5 to addr 3 in c0; req2 reads addr 3 and req3 reads addr 4, both valid from c0+1 -> req3 granted c0+1; req2 ready stays low until c0+3, then granted; req2 receives 0xA5 in c0+8.
4. Req0 read transferred in c0, i_rst=1 in c0+2 for one cycle -> no o_rsp_valid in c0+5; all outputs 0 during reset; first post-reset grant starts search from requester 0.
5. Req2 write only -> o_ram_we=1 for one cycle; o_rsp_valid stays 0 throughout.
6. No valid for 10 cycles -> o_req_ready=0000, o_ram_en=0, and the pointer does not move (next lone req3 request is granted immediately, then pointer=0).
